// File: rtl/vc_arbiter_router.sv
// Round-robin arbiter between four ingress VC FIFOs and four egress destination FIFOs.
// Pop -> capture -> push pipeline, with one push per cycle and a stall while any egress is almost full.
module vc_arbiter_router #(
  parameter int DATA_W   = 12,
  parameter int DEST_LSB = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          state,
  input  logic [3:0]          in_empty,
  input  logic [4*DATA_W-1:0] in_data,
  input  logic [3:0]          out_afull,
  output logic [3:0]          pop,
  output logic [3:0]          push,
  output logic [DATA_W-1:0]   data_out,
  output logic [7:0]          words_fwd,
  output logic                idle
);

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } gstate_e;

  logic [1:0]        ptr;
  logic              pend_valid;
  logic [1:0]        pend_sel;

  logic [3:0]        eligible;
  logic              grant_valid;
  logic [1:0]        grant_idx;
  logic [1:0]        cand;
  logic              do_pop;
  logic [1:0]        pop_idx;
  logic [DATA_W-1:0] cap_word;
  logic [1:0]        cap_dest;
  logic              sync_clear;

  // An input popped this cycle is locked out for one cycle so its empty flag can settle.
  // NOTE: every signal written in always_comb gets a default first, otherwise a path that skips it infers a latch.
  always_comb begin
    eligible    = ~in_empty & ~pop;
    grant_valid = 1'b0;
    grant_idx   = ptr;
    cand        = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign do_pop     = grant_valid && (state == ST_ACTIVE) && !(|out_afull);
  assign sync_clear = (state == ST_RESET);

  always_comb begin
    pop_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (pop[k]) pop_idx = 2'(k);
    end
  end

  // The FIFO popped in the previous cycle presents its word now; route it by its destination field.
  assign cap_word = in_data[pend_sel*DATA_W +: DATA_W];
  assign cap_dest = cap_word[DEST_LSB +: 2];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop        <= '0;
      push       <= '0;
      data_out   <= '0;
      words_fwd  <= '0;
      ptr        <= '0;
      pend_valid <= 1'b0;
      pend_sel   <= '0;
    end else if (sync_clear) begin
      pop        <= '0;
      push       <= '0;
      data_out   <= '0;
      words_fwd  <= '0;
      ptr        <= '0;
      pend_valid <= 1'b0;
      pend_sel   <= '0;
    end else begin
      pop <= do_pop ? (4'b0001 << grant_idx) : 4'b0000;
      if (do_pop) ptr <= grant_idx + 2'd1;

      // Words already popped always finish, whatever the global state does.
      pend_valid <= |pop;
      pend_sel   <= pop_idx;

      push <= pend_valid ? (4'b0001 << cap_dest) : 4'b0000;
      if (pend_valid) data_out <= cap_word;

      if (|push) words_fwd <= words_fwd + 8'd1;
    end
  end

  assign idle = !(|pop) && !pend_valid && !(|push);

endmodule

// File: tb/tb_vc_arbiter_router.sv
// Bench for vc_arbiter_router: queue-based ingress FIFOs, a cycle-level behavioural model
// of the arbitration rules, and scenario tasks for reset, fairness, lockout, backpressure and state drops.
module tb_vc_arbiter_router;
  localparam int DATA_W   = 12;
  localparam int DEST_LSB = 10;
  localparam logic [3:0] ST_RESET  = 4'b0001;
  localparam logic [3:0] ST_INIT   = 4'b0010;
  localparam logic [3:0] ST_IDLE   = 4'b0100;
  localparam logic [3:0] ST_ACTIVE = 4'b1000;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [3:0]          state = ST_ACTIVE;
  logic [3:0]          in_empty = 4'hF;
  logic [4*DATA_W-1:0] in_data = '0;
  logic [3:0]          out_afull = 4'h0;
  logic [3:0]          pop;
  logic [3:0]          push;
  logic [DATA_W-1:0]   data_out;
  logic [7:0]          words_fwd;
  logic                idle;

  vc_arbiter_router #(.DATA_W(DATA_W), .DEST_LSB(DEST_LSB)) dut (
    .clk       (clk),
    .reset     (reset),
    .state     (state),
    .in_empty  (in_empty),
    .in_data   (in_data),
    .out_afull (out_afull),
    .pop       (pop),
    .push      (push),
    .data_out  (data_out),
    .words_fwd (words_fwd),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Ingress FIFO contents as seen by the environment and, separately, by the reference model.
  logic [DATA_W-1:0] env_q [4][$];
  logic [DATA_W-1:0] m_q   [4][$];

  // Reference model: index of the input popped this cycle, the word awaiting push, the word being pushed.
  int                m_pop    = -1;
  bit                m_pend_v = 1'b0;
  logic [DATA_W-1:0] m_pend_d = '0;
  bit                m_push_v = 1'b0;
  logic [DATA_W-1:0] m_push_d = '0;
  logic [7:0]        m_cnt    = '0;
  int                m_ptr    = 0;

  int                cyc      = 0;
  int                push_cnt = 0;
  int                pop_log [$];
  int                pop_cyc [$];
  logic [DATA_W-1:0] push_log [$];

  // Advances the model over the clock edge that just passed, using the inputs held at that edge.
  task automatic model_step();
    int g;
    if (!reset || state == ST_RESET) begin
      m_pop = -1; m_pend_v = 1'b0; m_push_v = 1'b0; m_cnt = '0; m_ptr = 0;
      return;
    end
    if (m_push_v) m_cnt = m_cnt + 8'd1;
    m_push_v = m_pend_v;
    m_push_d = m_pend_d;
    m_pend_v = 1'b0;
    if (m_pop >= 0 && m_q[m_pop].size() > 0) begin
      m_pend_v = 1'b1;
      m_pend_d = m_q[m_pop].pop_front();
    end
    g = -1;
    if (state == ST_ACTIVE && out_afull == 4'h0) begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_ptr + k) % 4;
        if (g < 0 && in_empty[j] == 1'b0 && j != m_pop) g = j;
      end
    end
    m_pop = g;
    if (g >= 0) m_ptr = (g + 1) % 4;
  endtask

  // One clock: model update, lockstep comparison, logging, then the FIFOs react to the DUT's pop.
  task automatic next_cycle();
    logic [3:0] exp_pop, exp_push;
    logic       exp_idle;
    @(negedge clk);
    model_step();
    cyc++;
    exp_pop  = (m_pop >= 0) ? (4'b0001 << m_pop) : 4'b0000;
    exp_push = m_push_v ? (4'b0001 << m_push_d[DEST_LSB +: 2]) : 4'b0000;
    exp_idle = (m_pop < 0) && !m_pend_v && !m_push_v;
    total++;
    if (pop !== exp_pop) begin
      bad++; $display("FAIL pop @%0d: got %b want %b", cyc, pop, exp_pop);
    end
    total++;
    if (push !== exp_push) begin
      bad++; $display("FAIL push @%0d: got %b want %b", cyc, push, exp_push);
    end
    if (m_push_v) begin
      total++;
      if (data_out !== m_push_d) begin
        bad++; $display("FAIL data_out @%0d: got %h want %h", cyc, data_out, m_push_d);
      end
    end
    total++;
    if (words_fwd !== m_cnt) begin
      bad++; $display("FAIL words_fwd @%0d: got %0d want %0d", cyc, words_fwd, m_cnt);
    end
    total++;
    if (idle !== exp_idle) begin
      bad++; $display("FAIL idle @%0d: got %b want %b", cyc, idle, exp_idle);
    end
    for (int i = 0; i < 4; i++) begin
      if (pop[i]) begin pop_log.push_back(i); pop_cyc.push_back(cyc); end
    end
    if (push !== 4'b0000) begin
      push_cnt++;
      push_log.push_back(data_out);
    end
    for (int i = 0; i < 4; i++) begin
      if (pop[i] && env_q[i].size() > 0) in_data[i*DATA_W +: DATA_W] = env_q[i].pop_front();
      in_empty[i] = (env_q[i].size() == 0);
    end
    #1;
  endtask

  task automatic load(input int i, input logic [DATA_W-1:0] w);
    env_q[i].push_back(w);
    m_q[i].push_back(w);
    in_empty[i] = 1'b0;
  endtask

  task automatic run_until(input int target, input int budget);
    int n;
    n = 0;
    while (push_cnt < target && n < budget) begin
      next_cycle();
      n++;
    end
  endtask

  task automatic sync_reset();
    state = ST_RESET;
    next_cycle();
    state = ST_IDLE;
    next_cycle();
  endtask

  task automatic clear_logs();
    pop_log.delete(); pop_cyc.delete(); push_log.delete();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) load(i, 12'($urandom));
    state = ST_ACTIVE;
    reset = 1'b0;
    next_cycle();
    next_cycle();
    total++;
    if (pop !== 4'b0 || push !== 4'b0 || data_out !== '0 || words_fwd !== 8'd0 || idle !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: got pop=%b push=%b data=%h cnt=%0d idle=%b want all zero idle=1",
               pop, push, data_out, words_fwd, idle);
    end
    state = ST_IDLE;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin env_q[i].delete(); m_q[i].delete(); end
    in_empty = 4'hF;
    next_cycle();
  endtask

  task automatic test_single();
    int n;
    load(2, 12'hC35);
    state = ST_ACTIVE;
    n = 0;
    do begin next_cycle(); n++; end while (pop === 4'b0 && n < 10);
    total++;
    if (pop !== 4'b0100) begin bad++; $display("FAIL single_pop: got %b want 0100", pop); end
    next_cycle();
    next_cycle();
    total++;
    if (push !== 4'b1000 || data_out !== 12'hC35) begin
      bad++; $display("FAIL single_push: got push=%b data=%h want 1000 c35", push, data_out);
    end
    next_cycle();
    total++;
    if (words_fwd !== 8'd1) begin bad++; $display("FAIL single_count: got %0d want 1", words_fwd); end
    state = ST_IDLE;
    next_cycle();
  endtask

  task automatic test_fairness();
    logic [DATA_W-1:0] w [4][3];
    logic [DATA_W-1:0] seq [$];
    int base;
    sync_reset();
    total++;
    if (words_fwd !== 8'd0 || idle !== 1'b1) begin
      bad++; $display("FAIL sync_reset: got cnt=%0d idle=%b want 0 1", words_fwd, idle);
    end
    for (int i = 0; i < 4; i++)
      for (int r = 0; r < 3; r++) begin w[i][r] = 12'($urandom); load(i, w[i][r]); end
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 4; i++) seq.push_back(w[i][r]);
    clear_logs();
    base = push_cnt;
    state = ST_ACTIVE;
    run_until(base + 12, 60);
    total++;
    if (push_cnt - base != 12) begin bad++; $display("FAIL fair_count: got %0d want 12", push_cnt - base); end
    for (int k = 0; k < 12 && k < pop_log.size(); k++) begin
      total++;
      if (pop_log[k] != k % 4) begin bad++; $display("FAIL fair_order[%0d]: got %0d want %0d", k, pop_log[k], k % 4); end
    end
    for (int k = 0; k < 12 && k < push_log.size(); k++) begin
      total++;
      if (push_log[k] !== seq[k]) begin bad++; $display("FAIL fair_data[%0d]: got %h want %h", k, push_log[k], seq[k]); end
    end
    state = ST_IDLE;
  endtask

  task automatic test_lockout();
    logic [DATA_W-1:0] seq [$];
    int base;
    sync_reset();
    for (int r = 0; r < 4; r++) begin seq.push_back(12'($urandom)); load(1, seq[r]); end
    clear_logs();
    base = push_cnt;
    state = ST_ACTIVE;
    run_until(base + 4, 40);
    total++;
    if (push_cnt - base != 4 || pop_cyc.size() != 4) begin
      bad++; $display("FAIL lock_count: got pushes=%0d pops=%0d want 4 4", push_cnt - base, pop_cyc.size());
    end
    for (int k = 1; k < pop_cyc.size(); k++) begin
      total++;
      if (pop_cyc[k] - pop_cyc[k-1] != 2) begin
        bad++; $display("FAIL lock_gap[%0d]: got %0d want 2", k, pop_cyc[k] - pop_cyc[k-1]);
      end
    end
    for (int k = 0; k < 4 && k < push_log.size(); k++) begin
      total++;
      if (push_log[k] !== seq[k]) begin bad++; $display("FAIL lock_data[%0d]: got %h want %h", k, push_log[k], seq[k]); end
    end
    state = ST_IDLE;
  endtask

  task automatic test_backpressure();
    int base, at_raise;
    sync_reset();
    for (int i = 0; i < 4; i++)
      for (int r = 0; r < 6; r++) load(i, 12'($urandom));
    base = push_cnt;
    state = ST_ACTIVE;
    repeat (4) next_cycle();
    out_afull = 4'b0001;
    at_raise = push_cnt;
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      total++;
      if (pop !== 4'b0) begin bad++; $display("FAIL bp_stall[%0d]: got %b want 0000", k, pop); end
    end
    total++;
    if (push_cnt - at_raise > 2) begin
      bad++; $display("FAIL bp_late_pushes: got %0d want <=2", push_cnt - at_raise);
    end
    out_afull = 4'b0000;
    next_cycle();
    total++;
    if (pop === 4'b0) begin bad++; $display("FAIL bp_resume: got %b want one-hot", pop); end
    run_until(base + 24, 120);
    total++;
    if (push_cnt - base != 24) begin bad++; $display("FAIL bp_count: got %0d want 24", push_cnt - base); end
    state = ST_IDLE;
  endtask

  task automatic test_state_drop();
    logic [DATA_W-1:0] w0, w1;
    int base, n;
    sync_reset();
    w0 = 12'($urandom); w1 = 12'($urandom);
    load(0, w0); load(1, w1);
    base = push_cnt;
    state = ST_ACTIVE;
    n = 0;
    do begin next_cycle(); n++; end while (pop === 4'b0 && n < 10);
    total++;
    if (pop !== 4'b0001) begin bad++; $display("FAIL drop_pop: got %b want 0001", pop); end
    state = ST_IDLE;
    next_cycle();
    next_cycle();
    total++;
    if (push !== (4'b0001 << w0[DEST_LSB +: 2]) || data_out !== w0) begin
      bad++; $display("FAIL drop_push: got push=%b data=%h want dest %0d data %h", push, data_out, w0[DEST_LSB +: 2], w0);
    end
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      total++;
      if (pop !== 4'b0) begin bad++; $display("FAIL drop_nopop[%0d]: got %b want 0000", k, pop); end
    end
    state = ST_ACTIVE;
    run_until(base + 2, 20);
    total++;
    if (push_cnt - base != 2) begin bad++; $display("FAIL drop_count: got %0d want 2", push_cnt - base); end
    state = ST_IDLE;
  endtask

  task automatic test_wrap();
    int base;
    sync_reset();
    for (int r = 0; r < 65; r++)
      for (int i = 0; i < 4; i++) load(i, 12'($urandom));
    base = push_cnt;
    state = ST_ACTIVE;
    run_until(base + 260, 800);
    next_cycle();
    total++;
    if (push_cnt - base != 260 || words_fwd !== 8'd4) begin
      bad++; $display("FAIL wrap: got pushes=%0d cnt=%0d want 260 4", push_cnt - base, words_fwd);
    end
    state = ST_IDLE;
  endtask

  task automatic test_random();
    int base, loaded, i, pick;
    base = push_cnt;
    loaded = 0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) begin
        i = $urandom_range(3);
        if (env_q[i].size() < 8) begin load(i, 12'($urandom)); loaded++; end
      end
      out_afull = ($urandom_range(5) == 0) ? 4'($urandom) : 4'h0;
      if (c % 16 == 0) begin
        pick = $urandom_range(9);
        state = (pick < 7) ? ST_ACTIVE : (pick == 7) ? ST_IDLE : ST_INIT;
      end
      next_cycle();
    end
    out_afull = 4'h0;
    state = ST_ACTIVE;
    run_until(base + loaded, 200);
    total++;
    if (push_cnt - base != loaded) begin
      bad++; $display("FAIL rand_delivered: got %0d want %0d", push_cnt - base, loaded);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_lockout();
    test_backpressure();
    test_state_drop();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
